// File: rtl/aes_pkg.sv
// Shared AES-256 key-schedule types and constants: word type, schedule sizes,
// FSM states and the round-constant lookup.
package aes_pkg;

  typedef logic [31:0] aes_word_t;

  localparam int AES256_NK = 8;
  localparam int AES256_NR = 14;
  localparam int AES256_NW = 60;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OUT  = 2'd1,
    GEN  = 2'd2
  } state_t;

  // Rcon[1..7]; only indices 1..7 are ever used by the schedule
  function automatic logic [7:0] aes_rcon(input logic [2:0] n);
    logic [7:0] r;
    r = 8'h00;
    case (n)
      3'd1:    r = 8'h01;
      3'd2:    r = 8'h02;
      3'd3:    r = 8'h04;
      3'd4:    r = 8'h08;
      3'd5:    r = 8'h10;
      3'd6:    r = 8'h20;
      3'd7:    r = 8'h40;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box, computed as GF(2^8) inverse (x^254) followed by the
// affine transform, so no 256-entry table is needed.
module sbox (
  input  logic [7:0] in_i,
  output logic [7:0] out_o
);

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int n = 0; n < 8; n++) begin
      if (b[n]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int s);
    return (x << s) | (x >> (8 - s));
  endfunction

  logic [7:0] inv;

  // x^254 = prod x^(2^j), j=1..7; maps 0 to 0 without a special case
  always_comb begin
    logic [7:0] pw;
    pw  = in_i;
    inv = 8'h01;
    for (int j = 1; j < 8; j++) begin
      pw  = gmul(pw, pw);
      inv = gmul(inv, pw);
    end
  end

  assign out_o = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;

endmodule

// File: rtl/aes_subword.sv
// SubWord: four parallel S-box lookups over a 32-bit word, purely combinational.
module aes_subword
  import aes_pkg::*;
(
  input  aes_word_t word_i,
  output aes_word_t word_o
);

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    sbox u_sbox (
      .in_i  (word_i[8*b +: 8]),
      .out_o (word_o[8*b +: 8])
    );
  end

endmodule

// File: rtl/aes256_key_expand.sv
// Iterative AES-256 key schedule: one word per GEN cycle, round keys streamed
// over valid/ready. Optional AES_KEYEXP_ZEROIZE_EN wipes key material on completion.
module aes256_key_expand
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic [255:0] key,
  input  logic         start,
  input  logic         rk_ready,
  output logic         rk_valid,
  output logic [127:0] round_key,
  output logic [3:0]   round_idx,
  output logic         busy,
  output logic         done
);

  state_t          state_q, state_d;
  aes_word_t [7:0] w_q, w_d;     // w_q[0] is the oldest word
  logic [5:0]      i_q, i_d;
  logic [3:0]      k_q, k_d;
  logic            done_q, done_d;

  aes_word_t sub_in, sub_out, temp, new_w;

  assign sub_in = (i_q[2:0] == 3'd0) ? {w_q[7][23:0], w_q[7][31:24]} : w_q[7];

  aes_subword u_subword (
    .word_i (sub_in),
    .word_o (sub_out)
  );

  always_comb begin
    case (i_q[2:0])
      3'd0:    temp = sub_out ^ {aes_rcon(i_q[5:3]), 24'h0};
      3'd4:    temp = sub_out;
      default: temp = w_q[7];
    endcase
    new_w = w_q[0] ^ temp;
  end

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    i_d     = i_q;
    k_d     = k_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        // a start coinciding with the done pulse is dropped
        if (start && !done_q) begin
          for (int j = 0; j < 8; j++) w_d[j] = key[255 - 32*j -: 32];
          i_d     = 6'(AES256_NK);
          k_d     = 4'd0;
          state_d = OUT;
        end
      end
      OUT: begin
        if (rk_ready) begin
          if (k_q == 4'(AES256_NR)) begin
            state_d = IDLE;
            done_d  = 1'b1;
`ifdef AES_KEYEXP_ZEROIZE_EN
            w_d = '0;
`else
            w_d = w_q;
`endif
          end else if (k_q == 4'd0) begin
            k_d = 4'd1;
          end else begin
            k_d     = k_q + 4'd1;
            state_d = GEN;
          end
        end
      end
      GEN: begin
        w_d = {new_w, w_q[7:1]};
        i_d = (i_q == 6'(AES256_NW - 1)) ? i_q : i_q + 6'd1;
        if (i_q[1:0] == 2'd3) state_d = OUT;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      w_q     <= '0;
      i_q     <= 6'(AES256_NK);
      k_q     <= 4'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      i_q     <= i_d;
      k_q     <= k_d;
      done_q  <= done_d;
    end
  end

  assign rk_valid  = (state_q == OUT);
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign round_idx = k_q;

  always_comb begin
    round_key = (k_q == 4'd0) ? {w_q[0], w_q[1], w_q[2], w_q[3]}
                              : {w_q[4], w_q[5], w_q[6], w_q[7]};
`ifdef AES_KEYEXP_ZEROIZE_EN
    if (state_q != OUT) round_key = '0;
`else
    round_key = round_key;
`endif
  end

endmodule

// File: tb/tb_aes256_key_expand.sv
// Scoreboard bench for aes256_key_expand: reference key schedule pushes
// expected round keys at start, a negedge monitor pops them on each handshake.
module tb_aes256_key_expand;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         rk_ready = 1'b1;
  logic [255:0] key = '0;
  logic         rk_valid, busy, done;
  logic [127:0] round_key;
  logic [3:0]   round_idx;

  aes256_key_expand dut (
    .clk       (clk),
    .rst       (rst),
    .key       (key),
    .start     (start),
    .rk_ready  (rk_ready),
    .rk_valid  (rk_valid),
    .round_key (round_key),
    .round_idx (round_idx),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  localparam logic [0:255][7:0] TB_SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  localparam logic [255:0] K0  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] R0  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] R1  = 128'h101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] R2  = 128'ha573c29fa176c498a97fce93a572c09c;
  localparam logic [127:0] R14 = 128'h24fc79ccbf0979e9371ac23c6d68de36;

  int           n_chk = 0, n_fail = 0, done_cnt = 0, hold_cnt = 0;
  logic [127:0] exp_q[$];
  logic [3:0]   idx_q[$];
  logic [127:0] got_rk[15];
  logic         stall_mode = 1'b0;
  logic         prev_stall = 1'b0;
  logic [127:0] prev_key = '0;
  logic [3:0]   prev_idx = '0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] sub_m(input logic [31:0] x);
    return {TB_SBOX[x[31:24]], TB_SBOX[x[23:16]], TB_SBOX[x[15:8]], TB_SBOX[x[7:0]]};
  endfunction

  task automatic push_model(input logic [255:0] k);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int j = 0; j < 8; j++) w[j] = k[255 - 32*j -: 32];
    for (int i = 8; i < 60; i++) begin
      t = w[i-1];
      if (i % 8 == 0) begin
        rc = 8'h01 << (i/8 - 1);
        t  = sub_m({t[23:0], t[31:24]}) ^ {rc, 24'h0};
      end else if (i % 8 == 4) begin
        t = sub_m(t);
      end
      w[i] = w[i-8] ^ t;
    end
    for (int r = 0; r < 15; r++) begin
      exp_q.push_back({w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]});
      idx_q.push_back(4'(r));
    end
  endtask

  // Consumer back-pressure: 3-cycle stall at rounds 0, 1 and 7
  always @(posedge clk) begin
    #1;
    if (!stall_mode) rk_ready = 1'b1;
    else if (rk_valid && (round_idx == 0 || round_idx == 1 || round_idx == 7) && hold_cnt < 3) begin
      rk_ready = 1'b0;
      hold_cnt++;
    end else begin
      rk_ready = 1'b1;
      if (rk_valid && hold_cnt == 3) hold_cnt = 0;
    end
  end

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (prev_stall) begin
      chk("hold_vld", 128'(rk_valid), 128'd1);
      chk("hold_key", round_key, prev_key);
      chk("hold_idx", 128'(round_idx), 128'(prev_idx));
    end
    prev_stall = rk_valid && !rk_ready && !rst;
    prev_key   = round_key;
    prev_idx   = round_idx;
    if (rk_valid && rk_ready && !rst) begin
      if (exp_q.size() == 0) chk("sb_underflow", 128'(exp_q.size()), 128'd1);
      else begin
        chk("rk", round_key, exp_q.pop_front());
        chk("idx", 128'(round_idx), 128'(idx_q.pop_front()));
        got_rk[round_idx] = round_key;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [255:0] k);
    key = k;
    push_model(k);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    while (!done && n < budget) begin
      tick();
      n++;
    end
    chk(tag, 128'(done), 128'd1);
  endtask

  initial begin
    int n;
    logic [255:0] k1;
    int dcnt;
    k1 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};

    repeat (3) tick();
    chk("rst_vld", 128'(rk_valid), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_done", 128'(done), 128'd0);
    chk("rst_key", round_key, 128'd0);
    chk("rst_idx", 128'(round_idx), 128'd0);
    rst = 1'b0;
    tick();

    // Known-answer stream, ready tied high, latency of each milestone
    launch(K0);
    n = 1;
    chk("r0_vld", 128'(rk_valid), 128'd1);
    chk("r0_busy", 128'(busy), 128'd1);
    tick(); n++;
    chk("r1_vld", 128'(rk_valid), 128'd1);
    chk("r1_idx", 128'(round_idx), 128'd1);
    tick(); n++;
    chk("r2_gap", 128'(rk_valid), 128'd0);
    while (!done && n < 200) begin tick(); n++; end
    chk("done_lat", 128'(n), 128'd68);
    chk("done_busy", 128'(busy), 128'd0);
    chk("kat_r0", got_rk[0], R0);
    chk("kat_r1", got_rk[1], R1);
    chk("kat_r2", got_rk[2], R2);
    chk("kat_r14", got_rk[14], R14);
`ifdef AES_KEYEXP_ZEROIZE_EN
    chk("zero_key", round_key, 128'd0);
    chk("zero_wlo", 128'(dut.w_q[3:0]), 128'd0);
    chk("zero_whi", 128'(dut.w_q[7:4]), 128'd0);
`else
    chk("keep_key", round_key, R14);
`endif
    tick();
    chk("done_pulse", 128'(done), 128'd0);
    chk("sb_empty1", 128'(exp_q.size()), 128'd0);

    // Back-pressure at rounds 0, 1, 7
    stall_mode = 1'b1;
    launch(K0);
    wait_done("stall_done", 300);
    stall_mode = 1'b0;
    chk("sb_empty2", 128'(exp_q.size()), 128'd0);
    chk("stall_r14", got_rk[14], R14);
    tick();

    // Starts while busy and on the done cycle are ignored
    launch(k1);
    n = 1;
    while (!done && n < 200) begin
      if (n == 10) begin start = 1'b1; key = ~k1; end
      tick();
      start = 1'b0;
      n++;
    end
    chk("ign_done_lat", 128'(n), 128'd68);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("ign_busy", 128'(busy), 128'd0);
    chk("ign_vld", 128'(rk_valid), 128'd0);
    chk("sb_empty3", 128'(exp_q.size()), 128'd0);
    launch(K0);
    chk("fresh_busy", 128'(busy), 128'd1);
    chk("fresh_idx", 128'(round_idx), 128'd0);
    wait_done("fresh_done", 200);
    chk("sb_empty4", 128'(exp_q.size()), 128'd0);
    tick();

    // Reset during GEN of round 6
    launch(k1);
    n = 0;
    while (!(round_idx == 6 && !rk_valid) && n < 200) begin tick(); n++; end
    chk("gen6_seen", 128'(round_idx), 128'd6);
    rst = 1'b1;
    exp_q.delete();
    idx_q.delete();
    dcnt = done_cnt;
    tick();
    chk("mrst_vld", 128'(rk_valid), 128'd0);
    chk("mrst_busy", 128'(busy), 128'd0);
    chk("mrst_idx", 128'(round_idx), 128'd0);
    rst = 1'b0;
    repeat (80) tick();
    chk("mrst_nodone", 128'(done_cnt), 128'(dcnt));
    got_rk[0] = '0;
    launch(K0);
    chk("mrst_r0_vld", 128'(rk_valid), 128'd1);
    wait_done("mrst_done", 200);
    chk("mrst_r0", got_rk[0], R0);
    chk("sb_empty5", 128'(exp_q.size()), 128'd0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule

// File: doc/aes256_key_expand.md
# aes256_key_expand

Iterative AES-256 key-schedule engine. Accepts a 256-bit cipher key, expands it one 32-bit word per cycle through a SubWord stage built from four `sbox` instances, and streams the 15 round keys (rounds 0..14) in order. A valid/ready handshake lets the round datapath consume round keys at its own pace. The engine sits directly upstream of the encryption round datapath.

## Interface
- No parameters. The block is AES-256 only: Nk=8, Nr=14, 60 words, all fixed in the package.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `key` input 256: cipher key. `key[255:224]` is w0 and `key[31:0]` is w7. Sampled only on the cycle `start` is accepted.
- `start` input 1: begin expansion. Accepted only in IDLE; ignored otherwise.
- `rk_ready` input 1: the consumer accepts `round_key` this cycle.
- `rk_valid` output 1: `round_key` and `round_idx` are valid.
- `round_key` output 128: {w4k, w4k+1, w4k+2, w4k+3}, with w4k in [127:96].
- `round_idx` output 4: k, in the range 0..14.
- `busy` output 1: high in every state other than IDLE.
- `done` output 1: one-cycle pulse after round 14 is accepted.

## Operation
- Storage is an 8-word window W[0..7], oldest word first, plus a word counter i (6 bits, 8..59) and the round index.
- **IDLE:**
  - On `start`, load W from `key`, set i=8, set k=0, and go to OUT.
- **OUT:**
  - Present the round key with `rk_valid`=1:
    - k=0 presents W[0..3].
    - All other k present W[4..7].
  - On `rk_valid & rk_ready`:
    - If k=14, go to IDLE and pulse `done`.
    - If k=0, set k=1 and stay in OUT.
    - Otherwise, increment k and go to GEN.
- **GEN (exactly 4 cycles):** each cycle computes one word.
  - Set temp=W[7], then modify it by i mod 8:
    - If i mod 8 = 0: temp = SubWord(RotWord(temp)) ^ {Rcon[i/8], 24'h0}.
    - If i mod 8 = 4: temp = SubWord(temp).
  - new = W[0] ^ temp. Shift W left by one word, set W[7]=new, and increment i.
  - After the 4th cycle, go to OUT.
- RotWord rotates left by one byte. SubWord applies `sbox` to each byte.
- Rcon[1..7] = 01, 02, 04, 08, 10, 20, 40.
- All arithmetic is XOR only. i never exceeds 59.

## Timing
- Reset values:
  - `rk_valid`=0, `busy`=0, `done`=0, `round_key`=0, `round_idx`=0.
  - State is IDLE, i=8.
- With `start` accepted at cycle T and `rk_ready` tied high:
  - Round 0 is valid at T+1.
  - Round 1 is valid at T+2.
  - Round k≥2 is valid at T+5k−3; round 14 is valid at T+67.
  - `done` pulses at T+68. `busy` falls at T+68.
- For rounds 2..14, a handshake at cycle H gives `rk_valid` at H+5.
- While `rk_valid`=1 and `rk_ready`=0, `round_key` and `round_idx` hold stable. `rk_valid` never drops without a handshake.
- `rk_valid` does not depend combinationally on `rk_ready`.
- A `start` asserted while `busy` is ignored: there is no restart and no queuing.
- A `start` on the same cycle as `done` is ignored. A new start is accepted from T+69.
- Reset mid-operation:
  - Abort on the next edge and return to the reset values.
  - The partial key stream is discarded and no `done` is issued.
- The SubWord path is combinational within one GEN cycle: four `sbox` lookups followed by the XORs, inside one register stage.

## Configuration
- `AES_KEYEXP_ZEROIZE_EN`
- Defined:
  - W is cleared to zero on the cycle `done` pulses.
  - `round_key` is forced to 0 whenever `rk_valid`=0.
  - No key material remains in the block after completion.
- Undefined:
  - W retains the final window after completion.
  - `round_key` keeps its last value in IDLE.

## Structure
- Package `aes_pkg` holds:
  - `aes_word_t` (32-bit).
  - Constants `AES256_NK`=8, `AES256_NR`=14, `AES256_NW`=60.
  - Rcon table, indexed 1..7.
  - State enum: IDLE, OUT, GEN.
- Sub-module `aes_subword` takes a 32-bit word and returns a 32-bit word. It contains four `sbox` instances and is purely combinational.
- The top level holds the FSM, window shift register, counters and handshake.

## Test plan
- Key 000102…1e1f, `rk_ready`=1:
  - Round 0 = 000102030405060708090a0b0c0d0e0f.
  - Round 1 = 101112131415161718191a1b1c1d1e1f.
  - Round 2 = a573c29fa176c498a97fce93a572c09c.
  - Round 14 = 24fc79ccbf0979e9371ac23c6d68de36.
  - `done` at T+68.
- Same key, with `rk_ready` low for 3 cycles at each of rounds 0, 1 and 7:
  - Outputs hold stable while stalled.
  - The same 15 keys appear in the same order.
  - `round_idx` steps 0..14 with no gaps.
- `start` pulsed at T+10 and again on the `done` cycle:
  - Both pulses are ignored.
  - The stream is unaltered.
  - `start` at T+69 begins a fresh expansion.
- `rst` asserted during GEN for round 6, then released:
  - Next edge gives `rk_valid`=0, `busy`=0, `round_idx`=0.
  - No `done` is issued.
  - A new `start` yields the correct round 0.
- With `AES_KEYEXP_ZEROIZE_EN` defined:
  - After `done`, the internal window is 0 and `round_key`=0.
- With `AES_KEYEXP_ZEROIZE_EN` undefined:
  - After `done`, `round_key` retains 24fc79cc…de36.
